// File: rtl/viterbi_ber_checker.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_ber_checker
//  Purpose  : Bit-error-rate checker for the Viterbi chain. Searches the
//             decoder latency against a reference history, locks after a run
//             of matches, then counts compared bits and errors until a window
//             shows too many errors.
//  Options  : VITERBI_BER_FIRST_ERR_EN adds first_err_o / first_err_vld_o,
//             the 1-based locked bit index of the first error.
//  Revision : 1.0 - initial release
// ============================================================================
module viterbi_ber_checker #(
  parameter int MAX_LAT     = 64,
  parameter int LOCK_LEN    = 32,
  parameter int WIN         = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ref_i,
  input  logic                       ref_valid_i,
  input  logic                       dec_i,
  input  logic                       dec_valid_i,
  input  logic                       clear_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAT)-1:0] latency_o,
  output logic [31:0]                bit_cnt_o,
  output logic [31:0]                err_cnt_o,
`ifdef VITERBI_BER_FIRST_ERR_EN
  output logic [31:0]                first_err_o,
  output logic                       first_err_vld_o,
`endif
  output logic                       loss_o
);

  localparam int LW = $clog2(MAX_LAT);
  localparam int FW = LW + 1;
  localparam int RW = $clog2(LOCK_LEN + 1);
  localparam int BW = $clog2(WIN + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  localparam logic [FW-1:0] C_MAX_FILL = FW'(MAX_LAT);
  localparam logic [RW-1:0] C_LOCK_LEN = RW'(LOCK_LEN);
  localparam logic [BW-1:0] C_WIN      = BW'(WIN);
  localparam logic [EW-1:0] C_LOSS     = EW'(LOSS_THRESH);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [MAX_LAT-1:0] r_buf;
  logic [LW-1:0]      r_wp;
  logic [FW-1:0]      r_fill;
  logic [LW-1:0]      r_lat;
  logic [RW-1:0]      r_run;
  logic [BW-1:0]      r_win_bits;
  logic [EW-1:0]      r_win_errs;
  logic [31:0]        r_bit_cnt;
  logic [31:0]        r_err_cnt;
  logic               r_loss;

  logic [LW-1:0]      w_wp_next;
  logic [FW-1:0]      w_fill_next;
  logic [LW-1:0]      w_rd_idx;
  logic               w_target;
  logic               w_cmp;
  logic               w_mis;
  logic [BW-1:0]      w_wb_inc;
  logic [EW-1:0]      w_we_inc;
  logic [31:0]        w_bit_inc;
  logic [31:0]        w_err_inc;

  logic [LW-1:0]      w_lat_next;
  logic [RW-1:0]      w_run_next;
  logic [BW-1:0]      w_win_bits_next;
  logic [EW-1:0]      w_win_errs_next;
  logic [31:0]        w_bit_cnt_next;
  logic [31:0]        w_err_cnt_next;
  logic               w_loss_next;

  // Compare target: a same-cycle write at lat=0 is bypassed from ref_i since
  // the buffer has not been written yet.
  assign w_wp_next   = ref_valid_i ? r_wp + LW'(1) : r_wp;
  assign w_fill_next = (ref_valid_i && (r_fill != C_MAX_FILL)) ? r_fill + FW'(1) : r_fill;
  assign w_rd_idx    = w_wp_next - LW'(1) - r_lat;
  assign w_target    = (ref_valid_i && (w_rd_idx == r_wp)) ? ref_i : r_buf[w_rd_idx];
  assign w_cmp       = dec_valid_i && (w_fill_next > {1'b0, r_lat});
  assign w_mis       = dec_i ^ w_target;
  assign w_wb_inc    = r_win_bits + BW'(1);
  assign w_we_inc    = w_mis ? r_win_errs + EW'(1) : r_win_errs;
  assign w_bit_inc   = (r_bit_cnt == 32'hFFFF_FFFF) ? r_bit_cnt : r_bit_cnt + 32'd1;
  assign w_err_inc   = (r_err_cnt == 32'hFFFF_FFFF) ? r_err_cnt : r_err_cnt + 32'd1;

  // Reference history write; contents need no reset because fill gates reads.
  always_ff @(posedge clk) begin
    if (ref_valid_i) begin
      r_buf[r_wp] <= ref_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, latency search and counter update; clear overrides increments.
  always_comb begin
    w_state_next    = r_state;
    w_lat_next      = r_lat;
    w_run_next      = r_run;
    w_win_bits_next = r_win_bits;
    w_win_errs_next = r_win_errs;
    w_bit_cnt_next  = r_bit_cnt;
    w_err_cnt_next  = r_err_cnt;
    w_loss_next     = r_loss;
    case (r_state)
      ST_SEARCH: begin
        if (w_cmp) begin
          if (w_mis) begin
            w_run_next = '0;
            w_lat_next = r_lat + LW'(1);
          end else if ((r_run + RW'(1)) == C_LOCK_LEN) begin
            w_state_next    = ST_LOCKED;
            w_run_next      = '0;
            w_win_bits_next = '0;
            w_win_errs_next = '0;
          end else begin
            w_run_next = r_run + RW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (w_cmp) begin
          w_bit_cnt_next  = w_bit_inc;
          w_win_bits_next = w_wb_inc;
          if (w_mis) begin
            w_err_cnt_next  = w_err_inc;
            w_win_errs_next = w_we_inc;
          end
          if (w_we_inc == C_LOSS) begin
            w_state_next = ST_SEARCH;
            w_run_next   = '0;
            w_lat_next   = r_lat + LW'(1);
            w_loss_next  = 1'b1;
          end else if (w_wb_inc == C_WIN) begin
            w_win_bits_next = '0;
            w_win_errs_next = '0;
          end
        end
      end
      default: w_state_next = ST_SEARCH;
    endcase
    if (clear_i) begin
      w_bit_cnt_next  = '0;
      w_err_cnt_next  = '0;
      w_win_bits_next = '0;
      w_win_errs_next = '0;
      w_loss_next     = 1'b0;
    end
  end

  // Datapath registers: pointers, search state and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp       <= '0;
      r_fill     <= '0;
      r_lat      <= '0;
      r_run      <= '0;
      r_win_bits <= '0;
      r_win_errs <= '0;
      r_bit_cnt  <= '0;
      r_err_cnt  <= '0;
      r_loss     <= 1'b0;
    end else begin
      r_wp       <= w_wp_next;
      r_fill     <= w_fill_next;
      r_lat      <= w_lat_next;
      r_run      <= w_run_next;
      r_win_bits <= w_win_bits_next;
      r_win_errs <= w_win_errs_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_err_cnt  <= w_err_cnt_next;
      r_loss     <= w_loss_next;
    end
  end

`ifdef VITERBI_BER_FIRST_ERR_EN
  logic        r_first_vld;
  logic [31:0] r_first_err;
  logic        w_lock_evt;
  logic        w_err_evt;

  assign w_lock_evt = (r_state == ST_SEARCH) && (w_state_next == ST_LOCKED);
  assign w_err_evt  = (r_state == ST_LOCKED) && w_cmp && w_mis;

  // Capture the post-increment bit index of the first locked error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first_vld <= 1'b0;
      r_first_err <= '0;
    end else if (clear_i || w_lock_evt) begin
      r_first_vld <= 1'b0;
      r_first_err <= '0;
    end else if (w_err_evt && !r_first_vld) begin
      r_first_vld <= 1'b1;
      r_first_err <= w_bit_cnt_next;
    end
  end

  assign first_err_o     = r_first_err;
  assign first_err_vld_o = r_first_vld;
`endif

  assign locked_o  = (r_state == ST_LOCKED);
  assign latency_o = r_lat;
  assign bit_cnt_o = r_bit_cnt;
  assign err_cnt_o = r_err_cnt;
  assign loss_o    = r_loss;

endmodule
`default_nettype wire

// File: doc/viterbi_ber_checker.md
# viterbi_ber_checker

Receive-side bit-error-rate checker for the convolutional encode / channel / Viterbi decode chain. It taps the raw encoder input bits and the decoder output bits, then searches for the decoder latency in bit units. Once locked, it counts compared bits and bit errors until the link degrades. It sits beside the decoder in the tx/rx test harness and replaces per-cycle display-based checking with hardware counters usable in simulation and on FPGA.

## Interface
Parameters:
- MAX_LAT, 64, reference history depth in bits (power of 2); the largest searchable latency is MAX_LAT-1.
- LOCK_LEN, 32, consecutive matches required to declare lock.
- WIN, 64, bits per loss-detection window while locked.
- LOSS_THRESH, 8, errors within one window that force loss of lock.

Ports (reset rst, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ref_i  in  1  encoder input bit (reference)
- ref_valid_i  in  1  ref_i valid this cycle
- dec_i  in  1  decoder output bit
- dec_valid_i  in  1  dec_i valid this cycle
- clear_i  in  1  synchronous clear of counters and sticky flags; lock state is kept
- locked_o  out  1  in LOCKED state
- latency_o  out  $clog2(MAX_LAT)  current candidate / locked offset
- bit_cnt_o  out  32  bits compared while locked, saturating
- err_cnt_o  out  32  errors while locked, saturating
- loss_o  out  1  sticky: lock was lost at least once

## Operation
- History buffer: circular buffer of MAX_LAT bits with write pointer wp and fill count fill (saturates at MAX_LAT).
  - On ref_valid_i, the buffer writes ref_i at wp, then wp increments (wraps mod MAX_LAT).
- Compare target: the bit at (wp_next-1-lat) mod MAX_LAT, where wp_next includes a write made in the same cycle.
  - A ref and a dec arriving in the same cycle therefore align at lat=0.
- A compare happens only when dec_valid_i=1 and fill_next > lat. Otherwise the dec bit is dropped, with no state change.
- mismatch = dec_i ^ target.
- States:
  - SEARCH (reset state)
    - On a match, run increments.
    - On a mismatch, run clears to 0 and lat advances to (lat+1) mod MAX_LAT.
    - When run reaches LOCK_LEN, the block goes to LOCKED and clears win_bits and win_errs.
  - LOCKED
    - Each compare increments bit_cnt, and win_bits.
    - Each mismatch increments err_cnt and win_errs.
    - If win_errs reaches LOSS_THRESH, the block goes to SEARCH, run=0, lat advances by 1, and loss_o is set.
    - Otherwise, when win_bits reaches WIN, both window counters clear.
- bit_cnt and err_cnt saturate at 32'hFFFF_FFFF. They are never updated in SEARCH.
- clear_i zeroes bit_cnt, err_cnt, win_bits, win_errs and loss_o.
  - clear_i has priority over any same-cycle increment.
  - The state and lat are unchanged.
- Mid-operation reset returns everything to reset values. Buffer contents are don't-care because fill=0.

## Timing
- Reset values:
  - locked_o=0, latency_o=0, bit_cnt_o=0, err_cnt_o=0, loss_o=0.
  - Internal: wp=0, fill=0, run=0.
- All outputs are registered, with a 1-cycle latency from the qualifying dec_valid_i edge.
  - locked_o rises in the cycle after the LOCK_LEN-th consecutive match.
  - The counters reflect a compare one cycle after it.
- There is no backpressure; inputs are accepted every cycle.
- Window and loss decisions use the post-increment counts of the same compare.

## Configuration
- Macro: VITERBI_BER_FIRST_ERR_EN.
- Defined:
  - Adds output first_err_o[31:0], reset 0.
  - On the first mismatch while locked since reset, clear_i, or the most recent lock, it captures the bit_cnt value (post-increment, so the index is 1-based).
  - A valid flag first_err_vld_o (1 bit) accompanies it, sticky until clear_i or re-lock.
- Undefined: neither port exists, and no capture logic is synthesized.

## Test plan
- Clean link, decoder delay 5 bits (dec equals ref delayed 5 valid beats), LFSR data.
  - locked_o=1 after 5 search mismatches plus 32 matches; latency_o=5.
  - After 1000 more bits: bit_cnt_o=1000, err_cnt_o=0.
- Locked at latency 5, flip dec bits at locked indices 10 and 11.
  - err_cnt_o=2; locked_o stays 1; loss_o=0.
  - With the macro defined: first_err_o=10.
- Locked, then 8 errors in one 64-bit window.
  - locked_o=0 the next cycle; loss_o=1; latency_o=6.
  - After the corruption stops, the search wraps through 63→0 and relocks at 5.
- Same-cycle ref/dec, dec=ref with no delay: locks at latency_o=0 after 32 bits.
- clear_i pulsed while locked with bit_cnt_o=500, same cycle as a compare.
  - Next cycle bit_cnt_o=0, err_cnt_o=0, loss_o=0; locked_o=1.
- rst asserted mid-lock.
  - All outputs 0 immediately; relock takes a full 32-match sequence after release.
